// File: rtl/fast_conf_pkg.sv
// Shared constants and state types for the FAST configuration packet parser
// and its read-response engine.
package fast_conf_pkg;

    localparam int BEAT_W = 134;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_BODY = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    localparam logic [15:0] TYPE_SEL = 16'h9001;
    localparam logic [15:0] TYPE_WR  = 16'h9003;
    localparam logic [15:0] TYPE_RD  = 16'h9004;

    // Bit positions inside a 134-bit beat (payload occupies [127:0])
    localparam int TAG_HI  = 133;
    localparam int TAG_LO  = 132;
    localparam int TYPE_HI = 31;
    localparam int TYPE_LO = 16;
    localparam int ADDR_HI = 47;
    localparam int ADDR_LO = 16;
    localparam int DATA_HI = 79;
    localparam int DATA_LO = 48;
    localparam int SEL_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_TYPE,
        ST_SEL_B,
        ST_WR_B,
        ST_RD_B,
        ST_DROP
    } parse_state_e;

    typedef enum logic [2:0] {
        RSP_IDLE,
        RSP0,
        RSP1,
        RSP2,
        RSP3
    } rsp_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fast_conf_rsp_tx.sv
// Four-beat read-response engine: started by the TCM read strobe, captures the
// read data one cycle later and emits a head/body/body/tail response packet.
module fast_conf_rsp_tx
    import fast_conf_pkg::*;
#(
    parameter int TCM_AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [TCM_AW-1:0] addr_i,
    input  logic [31:0]       rdata_i,
    output logic [BEAT_W-1:0] data_o,
    output logic              valid_o,
    output logic              busy_o
);

    rsp_state_e        state_q, state_d;
    logic [BEAT_W-1:0] data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [TCM_AW-1:0] addr_q, addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RSP_IDLE;
            data_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
        end
    end

    // data_q holds the beat being presented while state_q names it
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        case (state_q)
            RSP_IDLE: begin
                if (start_i) begin
                    state_d = RSP0;
                    addr_d  = addr_i;
                    data_d  = {TAG_HEAD, 4'd0, 128'd0};
                end
            end
            RSP0: begin
                rdata_d = rdata_i;
                data_d  = {TAG_BODY, 4'd0, 128'd0};
                state_d = RSP1;
            end
            RSP1: begin
                data_d  = {TAG_BODY, 4'd0, 96'd0, TYPE_RD, 16'd0};
                state_d = RSP2;
            end
            RSP2: begin
                data_d  = {TAG_TAIL, 4'd0, 48'd0, rdata_q,
                           {(32-TCM_AW){1'b0}}, addr_q, 16'd0};
                state_d = RSP3;
            end
            default: state_d = RSP_IDLE;
        endcase
    end

    assign data_o  = data_q;
    assign valid_o = (state_q != RSP_IDLE);
    assign busy_o  = valid_o | start_i;

endmodule

// File: rtl/fast_conf_parser.sv
// FAST configuration packet parser: turns config beats into TCM writes/reads and cpu_run.
// Define FAST_CONF_ADDR_CHECK_EN to drop TCM accesses whose address is >= TCM_DEPTH.
module fast_conf_parser
    import fast_conf_pkg::*;
#(
    parameter int TCM_AW    = 14,
    parameter int TCM_DEPTH = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in_valid,
    input  logic [BEAT_W-1:0] data_in,
    output logic              data_out_valid,
    output logic [BEAT_W-1:0] data_out,
    output logic              tcm_wren,
    output logic              tcm_rden,
    output logic [TCM_AW-1:0] tcm_addr,
    output logic [31:0]       tcm_wdata,
    input  logic [31:0]       tcm_rdata,
    output logic              cpu_run,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       drop_cnt
);

    parse_state_e      state_q, state_d;
    logic              wren_q, wren_d;
    logic              rden_q, rden_d;
    logic              run_q, run_d;
    logic [TCM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              wr_inc, drop_inc;
    logic              rsp_busy;

    logic [1:0]  tag;
    logic        is_head, is_tail;
    logic [15:0] beat_type;
    logic [31:0] beat_addr, beat_data;
    logic        beat_sel;
    logic        in_range, addr_ok;

    assign tag       = data_in[TAG_HI:TAG_LO];
    assign is_head   = (tag == TAG_HEAD);
    assign is_tail   = (tag == TAG_TAIL);
    assign beat_type = data_in[TYPE_HI:TYPE_LO];
    assign beat_addr = data_in[ADDR_HI:ADDR_LO];
    assign beat_data = data_in[DATA_HI:DATA_LO];
    assign beat_sel  = data_in[SEL_BIT];
    assign in_range  = (beat_addr < 32'(TCM_DEPTH));

`ifdef FAST_CONF_ADDR_CHECK_EN
    assign addr_ok = in_range;
`else
    assign addr_ok = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^{data_in[131:128], data_in[127:80], data_in[15:0], in_range};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wren_q     <= 1'b0;
            rden_q     <= 1'b0;
            run_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wren_q     <= wren_d;
            rden_q     <= rden_d;
            run_q      <= run_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_cnt_q   <= wr_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        run_d    = run_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_inc   = 1'b0;
        drop_inc = 1'b0;
        if (data_in_valid) begin
            if (state_q == ST_IDLE) begin
                if (is_head) state_d = ST_HDR1;
            end else if (is_head) begin
                // A head mid-packet abandons the old packet and starts the new one
                drop_inc = 1'b1;
                state_d  = ST_HDR1;
            end else begin
                case (state_q)
                    ST_HDR1: begin
                        state_d  = ST_TYPE;
                        drop_inc = is_tail;
                    end
                    ST_TYPE: begin
                        if (is_tail) begin
                            drop_inc = 1'b1;
                        end else begin
                            case (beat_type)
                                TYPE_SEL: state_d = ST_SEL_B;
                                TYPE_WR:  state_d = ST_WR_B;
                                TYPE_RD:  state_d = ST_RD_B;
                                default: begin
                                    state_d  = ST_DROP;
                                    drop_inc = 1'b1;
                                end
                            endcase
                        end
                    end
                    ST_WR_B: begin
                        if (addr_ok) begin
                            wren_d  = 1'b1;
                            addr_d  = beat_addr[TCM_AW-1:0];
                            wdata_d = beat_data;
                            wr_inc  = 1'b1;
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end
                    // SEL and RD act on beat 3 only; the rest of the packet is skipped
                    ST_SEL_B: begin
                        run_d   = beat_sel;
                        state_d = ST_DROP;
                    end
                    ST_RD_B: begin
                        if (addr_ok && !rsp_busy) begin
                            rden_d = 1'b1;
                            addr_d = beat_addr[TCM_AW-1:0];
                        end else begin
                            drop_inc = 1'b1;
                        end
                        state_d = ST_DROP;
                    end
                    default: ;
                endcase
                if (is_tail) state_d = ST_IDLE;
            end
        end
    end

    assign wr_cnt_d   = wr_inc   ? sat_inc(wr_cnt_q)   : wr_cnt_q;
    assign drop_cnt_d = drop_inc ? sat_inc(drop_cnt_q) : drop_cnt_q;

    fast_conf_rsp_tx #(
        .TCM_AW (TCM_AW)
    ) u_rsp_tx (
        .clk     (clk),
        .rst     (rst),
        .start_i (rden_q),
        .addr_i  (addr_q),
        .rdata_i (tcm_rdata),
        .data_o  (data_out),
        .valid_o (data_out_valid),
        .busy_o  (rsp_busy)
    );

    assign tcm_wren  = wren_q;
    assign tcm_rden  = rden_q;
    assign tcm_addr  = addr_q;
    assign tcm_wdata = wdata_q;
    assign cpu_run   = run_q;
    assign wr_cnt    = wr_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/fast_conf_parser.md
Name: fast_conf_parser

Overview:
- Receiver/responder for FAST configuration packets (134-bit beats) that program the CPU's ITCM/DTCM and CPU run-select.
- Sits between the packet input path and the TCM write/read ports; the other end of the configuration packet generator.
- Decodes the packet type, issues TCM writes and reads, and drives cpu_run.
- Returns one FAST response packet per TCM read request.

Parameters:
- TCM_AW, 14, TCM word-address width (16384 words = 64 KB).
- TCM_DEPTH, 16384, number of valid TCM words; used only by the optional address check.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- data_in_valid  in  1  input beat valid; no backpressure.
- data_in  in  134  input beat: [133:132] tag (01 head, 11 middle, 10 tail), [131:128] reserved, [127:0] payload.
- data_out_valid  out  1  response beat valid.
- data_out  out  134  response beat, same format as data_in.
- tcm_wren  out  1  one-cycle TCM write strobe.
- tcm_rden  out  1  one-cycle TCM read strobe.
- tcm_addr  out  TCM_AW  TCM word address.
- tcm_wdata  out  32  TCM write data.
- tcm_rdata  in  32  TCM read data, valid exactly 1 cycle after tcm_rden.
- cpu_run  out  1  CPU run select, 1 = run.
- wr_cnt  out  16  count of TCM writes issued, saturating.
- drop_cnt  out  16  count of dropped packets/requests, saturating.

Behaviour:
- Reset: all outputs 0; state IDLE.
- Beat index counts accepted beats from the head (head = 0). Cycles with data_in_valid = 0 are ignored and hold the state.
- Type field: payload [31:16] of beat 2.
  - 0x9001 SEL
  - 0x9003 TCM write
  - 0x9004 TCM read
  - any other value: DROP
- Address field: payload [47:16]; tcm_addr takes the low TCM_AW bits. Data field: payload [79:48].
- States:
  - IDLE: tag 01 -> HDR1; any other tag is ignored.
  - HDR1: next beat -> TYPE.
  - TYPE: decode the type -> SEL_B, WR_B, RD_B or DROP. Unknown type increments drop_cnt.
  - WR_B: every beat, including the tail, issues tcm_wren = 1 with the beat's addr/data in the same cycle it is registered (1-cycle latency from beat to strobe); wr_cnt++.
  - SEL_B: beat 3 payload bit [16] loads cpu_run; later beats are ignored.
  - RD_B: beat 3 pulses tcm_rden with its address and loads the response engine; later beats are ignored.
  - DROP: consume beats until the tail.
- Any tag 10 in a non-IDLE state -> IDLE after processing that beat.
- A tag 10 at beat 1 or beat 2 aborts the packet: no side effects, drop_cnt++.
- A tag 01 in a non-IDLE state aborts the current packet: drop_cnt++, restart at HDR1. The head beat is consumed.
- Response engine (RSP0..RSP3):
  - Starts the cycle after tcm_rden; it captures tcm_rdata in that cycle.
  - Emits 4 consecutive valid beats:
    - RSP0: {01, 0, 128'd0}
    - RSP1: {11, 0, 128'd0}
    - RSP2: {11, 0, 96'd0, 16'h9004, 16'd0}
    - RSP3: {10, 0, 48'd0, rdata, zero-extended addr, 16'd0}
  - data_out_valid is 0 otherwise; data_out holds its last value.
- A read request arriving while the engine is busy: the read is dropped (no tcm_rden), drop_cnt++.
- Write vs read port: writes and reads never coincide because only one packet is in flight. tcm_addr is muxed by the active strobe and holds its last value otherwise.
- Counters saturate at 0xFFFF.
- rst mid-packet or mid-response: immediate return to reset values; any partial response is truncated.

Optional Feature:
- Macro FAST_CONF_ADDR_CHECK_EN.
- Defined: a WR_B beat or RD_B request with address >= TCM_DEPTH issues no strobe and increments drop_cnt (once per beat); wr_cnt is unchanged.
- Undefined: the address is silently truncated to TCM_AW bits and always issued.

Decomposition:
- Package fast_conf_pkg:
  - tag constants TAG_HEAD/TAG_BODY/TAG_TAIL
  - type constants TYPE_SEL/TYPE_WR/TYPE_RD
  - field bit-position localparams
  - parser state enum
- Sub-module fast_conf_rsp_tx: the 4-beat response engine (start, addr, rdata in; data_out/valid and busy out).

Test Plan:
- Write packet, type 0x9003, with 2001 body beats at addr 0..2000, data = 0x1000_0000+addr -> 2001 tcm_wren pulses; wr_cnt = 2001; read-back via 0x9004 matches.
- Read packet, type 0x9004, addr 128, TCM holds 0xDEADBEEF -> tcm_rden at beat 3; 4 response beats start 1 cycle later; RSP3 payload [79:48] = 0xDEADBEEF, [47:16] = 128.
- SEL packet with beat 3 bit16 = 1, then a second SEL packet with bit16 = 0 -> cpu_run rises, then falls; no TCM strobes.
- Type 0x1234 packet, then a head beat in the middle of a write packet -> drop_cnt = 2; no strobes from either aborted packet; the following packet decodes correctly.
- data_in_valid toggled 0/1 every cycle during a write packet -> same writes as the unbroken stream; rst asserted during RSP1 -> data_out_valid 0 immediately, all counters 0.
- With FAST_CONF_ADDR_CHECK_EN, writes to addr 16383 and 16384 -> one tcm_wren; drop_cnt = 1.
